// File: rtl/magnitude_arbiter.sv
// Round-robin arbiter feeding a shared two-stage magnitude pipeline,
// r ~= max(|x|,|y|) + min(|x|,|y|)/4, with a channel tag and valid/ready output.
module magnitude_arbiter #(
  parameter int N_CH = 4,
  parameter int W    = 16,
  parameter int CW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*W-1:0]      x_in,
  input  logic [N_CH*W-1:0]      y_in,
  output logic [N_CH-1:0]        ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    out_r,
  output logic [CW-1:0]          out_ch,
  output logic                   busy,
  output logic [15:0]            sat_cnt
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // Returns {clipped, |v|}; the most negative code clips to MAXV.
  function automatic logic [W:0] abs_sat(input logic signed [W-1:0] v);
    if (v == MINV)
      return {1'b1, MAXV};
    else if (v < 0)
      return {1'b0, -v};
    else
      return {1'b0, v};
  endfunction

  // Returns {clipped, ma + mi/4} limited to MAXV.
  function automatic logic [W:0] sum_sat(input logic [W-1:0] ma, input logic [W-1:0] mi);
    logic [W:0] s;
    s = {1'b0, ma} + {3'b000, mi[W-1:2]};
    if (s[W] | s[W-1])
      return {1'b1, MAXV};
    else
      return {1'b0, s[W-1:0]};
  endfunction

  logic                 adv;
  logic [CW-1:0]        ptr;
  logic                 found;
  logic [CW-1:0]        gidx;
  logic [CW:0]          pos;
  logic signed [W-1:0]  x_sel, y_sel;

  logic                 vld_p1;
  logic signed [W-1:0]  x_p1, y_p1;
  logic [CW-1:0]        ch_p1;

  logic [W:0]           ax_s, ay_s, sm_s;
  logic [W-1:0]         ax, ay, ma, mi;
  logic [W-1:0]         r_p1;
  logic                 clip_p1;

  assign adv  = !out_valid | out_ready;
  assign busy = vld_p1 | out_valid;

  // Search upward from ptr, wrapping at N_CH.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    pos   = '0;
    for (int k = 0; k < N_CH; k++) begin
      pos = {1'b0, ptr} + (CW+1)'(k);
      if (pos >= (CW+1)'(N_CH))
        pos = pos - (CW+1)'(N_CH);
      if (!found && req[pos[CW-1:0]]) begin
        found = 1'b1;
        gidx  = pos[CW-1:0];
      end
    end
  end

  always_comb begin
    ack = '0;
    if (adv && found && !reset)
      ack[gidx] = 1'b1;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gidx == CW'(i)) begin
        x_sel = x_in[i*W +: W];
        y_sel = y_in[i*W +: W];
      end
    end
  end

  always_comb begin
    ax_s = abs_sat(x_p1);
    ay_s = abs_sat(y_p1);
    ax   = ax_s[W-1:0];
    ay   = ay_s[W-1:0];
    if (ax > ay) begin
      ma = ax;
      mi = ay;
    end else begin
      ma = ay;
      mi = ax;
    end
    sm_s    = sum_sat(ma, mi);
    r_p1    = sm_s[W-1:0];
    clip_p1 = ax_s[W] | ay_s[W] | sm_s[W];
  end

  // Stage 1: capture the granted sample
  always_ff @(posedge clk) begin
    if (adv) begin
      x_p1  <= x_sel;
      y_p1  <= y_sel;
      ch_p1 <= gidx;
    end
  end

  // Stage 2: output register and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_ch    <= '0;
      sat_cnt   <= '0;
    end else if (adv) begin
      vld_p1    <= |ack;
      if (|ack)
        ptr <= (gidx == CW'(N_CH-1)) ? '0 : gidx + CW'(1);
      out_valid <= vld_p1;
      out_r     <= r_p1;
      out_ch    <= ch_p1;
      if (vld_p1 && clip_p1 && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_magnitude_arbiter.sv
// Directed bench for magnitude_arbiter: arithmetic, saturation, round-robin order,
// backpressure and reset in flight.
module tb_magnitude_arbiter;
  localparam int N_CH = 4;
  localparam int W    = 16;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   req;
  logic [N_CH*W-1:0] x_in, y_in;
  logic [N_CH-1:0]   ack;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_r;
  logic [CW-1:0]     out_ch;
  logic              busy;
  logic [15:0]       sat_cnt;

  int checks = 0;
  int errors = 0;
  int rr_ack [10] = '{0, 1, 2, 3, 0, 1, 3, 1, -1, -1};

  magnitude_arbiter #(.N_CH(N_CH), .W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_ch(out_ch),
    .busy(busy), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int ch, input int x, input int y);
    x_in[ch*W +: W] = W'(x);
    y_in[ch*W +: W] = W'(y);
  endtask

  task automatic send_one(input int ch, input int x, input int y, input int exp_r);
    set_xy(ch, x, y);
    req = N_CH'(1 << ch);
    #2;
    check("one_ack", ack, 1 << ch);
    cyc;
    req = '0;
    #2;
    check("one_busy", busy, 1);
    check("one_lat", out_valid, 0);
    cyc;
    #2;
    check("one_valid", out_valid, 1);
    check("one_r", out_r, exp_r);
    check("one_ch", out_ch, ch);
    cyc;
  endtask

  initial begin
    int s, e;
    reset = 1'b1;
    req = '0;
    x_in = '0;
    y_in = '0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_cnt, 0);
    check("rst_r", out_r, 0);
    check("rst_ch", out_ch, 0);
    req = 4'b0001;
    #1;
    check("rst_ack", ack, 0);
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    send_one(0, 3, 4, 4);
    send_one(0, 100, -40, 110);
    check("sat_none", sat_cnt, 0);
    send_one(0, -32768, -32768, 32767);
    check("sat_one", sat_cnt, 1);
    send_one(0, 32767, 32767, 32767);
    check("sat_two", sat_cnt, 2);

    reset = 1'b1;
    #2;
    check("rst2_sat", sat_cnt, 0);
    reset = 1'b0;

    for (int i = 0; i < N_CH; i++) set_xy(i, 10*(i+1), -4*(i+1));
    for (int k = 0; k < 10; k++) begin
      req = (k < 6) ? 4'b1111 : (k < 8) ? 4'b1010 : 4'b0000;
      #2;
      check($sformatf("rr_ack%0d", k), ack, (rr_ack[k] < 0) ? 0 : (1 << rr_ack[k]));
      if (k >= 2) begin
        check($sformatf("rr_valid%0d", k), out_valid, 1);
        check($sformatf("rr_ch%0d", k), out_ch, rr_ack[k-2]);
        check($sformatf("rr_r%0d", k), out_r, 11*(rr_ack[k-2]+1));
      end
      cyc;
    end
    #2;
    check("rr_idle", out_valid, 0);

    s = 0;
    e = 0;
    for (int k = 0; k < 40 && e < 10; k++) begin
      out_ready = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      req = (s < 10) ? 4'b0100 : 4'b0000;
      set_xy(2, 1000 + s, 0);
      #2;
      if (k >= 2) check($sformatf("bp_valid%0d", k), out_valid, 1);
      if (!out_ready) begin
        check($sformatf("bp_ack%0d", k), ack, 0);
        check($sformatf("bp_hold_r%0d", k), out_r, 1000 + e);
        check($sformatf("bp_hold_ch%0d", k), out_ch, 2);
      end else if (out_valid) begin
        check($sformatf("bp_r%0d", e), out_r, 1000 + e);
        check($sformatf("bp_ch%0d", e), out_ch, 2);
        e++;
      end
      if (ack[2]) s++;
      cyc;
    end
    check("bp_count", e, 10);
    out_ready = 1'b1;
    req = '0;
    #2;
    check("bp_drain", out_valid, 0);

    req = 4'b1111;
    cyc;
    cyc;
    #2;
    check("mid_full_busy", busy, 1);
    check("mid_full_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_ack", ack, 0);
    cyc;
    check("mid_hold_valid", out_valid, 0);
    req = 4'b1000;
    set_xy(3, 7, 24);
    reset = 1'b0;
    #1;
    check("mid_ack3", ack, 4'b1000);
    cyc;
    req = '0;
    #2;
    check("mid_no_stale", out_valid, 0);
    cyc;
    #2;
    check("mid_valid3", out_valid, 1);
    check("mid_ch3", out_ch, 3);
    check("mid_r3", out_r, 25);
    cyc;
    #2;
    check("mid_end", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/magnitude_arbiter.md
# magnitude_arbiter

Round-robin scheduler that shares one pipelined magnitude-approximation datapath, r = max(|x|,|y|) + min(|x|,|y|)/4, between N_CH requesting channels. It accepts one (x,y) sample per cycle from the winning channel and tags each result with its source channel. Results leave on a valid/ready output port with full backpressure. The block sits between per-channel I/Q front ends and downstream envelope/detector logic.

## Interface
- N_CH, default 4: number of requesting channels (2..8).
- W, default 16: sample and result width (signed two's complement).
- CW, default 2: channel-tag width, ceil(log2(N_CH)).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_CH  per-channel request; bit i high means x_in/y_in slice i holds a valid sample.
- x_in  in  N_CH*W  packed x samples; channel i at bits [i*W +: W].
- y_in  in  N_CH*W  packed y samples, same packing.
- ack  out  N_CH  one-hot; bit i high means channel i's sample is captured at this rising edge.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_r  out  W  magnitude result, signed, always >= 0.
- out_ch  out  CW  channel tag of out_r.
- busy  out  1  high when any pipeline stage holds data.
- sat_cnt  out  16  count of saturated results since reset; saturates at 0xFFFF.

## Operation
- Pipeline: S1 (captured x, y, ch, valid) feeds S2 (output register: out_r, out_ch, out_valid).
- Advance enable: adv = !out_valid | out_ready. When adv=0, S1 and S2 hold and ack is all-zero.
- Arbitration: when adv=1 and req != 0, grant the first requesting channel searching upward (mod N_CH) from ptr. ack is one-hot, combinational from req, ptr, out_valid and out_ready. After a grant to channel g, ptr <= (g+1) mod N_CH. With no grant, ptr holds.
- S1 load on adv: S1.valid <= |ack. S1.x/y/ch are loaded from the granted channel. Otherwise S1.valid is cleared.
- S2 load on adv: out_valid <= S1.valid. out_r and out_ch are computed from S1.
- Arithmetic, in S2:
  - |v| = v if v >= 0, else -v. The value -2^(W-1) saturates to 2^(W-1)-1.
  - ma = larger of |x| and |y|; mi = the other (ma = ay when |x| == |y|).
  - Sum = ma + (mi >> 2), computed at W+1 bits. If the sum exceeds 2^(W-1)-1, out_r = 2^(W-1)-1.
  - sat_cnt increments on each S2 load whose value was clipped, either by the abs step or the sum step.
- Requester protocol:
  - Hold req, x and y stable until ack is seen.
  - req may drop without ack; no state is affected.
  - A requester holding req continuously is served at most once per N_CH grants when others are requesting.
- busy = S1.valid | out_valid.

## Timing
- Reset (async, immediate):
  - ptr=0, so channel 0 has highest priority.
  - S1.valid=0, out_valid=0, out_r=0, out_ch=0, ack=0, busy=0, sat_cnt=0.
- Reset mid-operation discards all in-flight samples; no result is emitted for them.
- Latency: a sample acked in cycle t appears with out_valid=1 in cycle t+2.
- Throughput: one result per cycle while out_ready=1 and requests are present.
- Backpressure:
  - out_valid=1 with out_ready=0 freezes out_r, out_ch, S1 and ptr, and forces ack=0.
  - Transfer occurs on a rising edge with out_valid & out_ready.
  - Simultaneous transfer and new load is allowed (adv=1), so there are no bubbles.
- Single requester: granted every cycle while adv=1.

## Test plan
- Basic: ch0 x=3, y=4 -> ack[0] in cycle 0; out_valid in cycle 2 with out_r=4, out_ch=0. Also x=100, y=-40 -> 110.
- Saturation: x=-32768, y=-32768 -> out_r=32767, sat_cnt=1. Then x=32767, y=32767 -> out_r=32767, sat_cnt=2.
- Round-robin: req=4'b1111 held with out_ready=1 -> ack order ch0,1,2,3,0,1. Each result is tagged with the matching out_ch, two cycles after its ack. Then req=4'b1010 with ptr=2 -> ch3 first, then ch1.
- Backpressure: stream on ch2, out_ready=0 for 5 cycles. Required: out_r and out_ch stable, ack=0, no sample lost or duplicated. On out_ready=1, results resume in order, one per cycle.
- Reset mid-operation: assert reset with S1 and S2 full -> out_valid=0, busy=0 immediately. After release with req=4'b1000, ack[3] comes first (ptr reset to 0, lowest active index above it wins). No stale result appears.
